lsu_mem_resp: RTL and testbench
===============================

# lsu_mem_resp

Load/store responder at the memory end of the MEM-stage LSU handshake. Accepts one load (`lsu_r_ready`) or store (`lsu_w_valid`) request at a time from the MEM/WB stage and forwards it as an aligned 64-bit access on a simple req/gnt/rvalid data-memory port. Returns a single-cycle completion pulse (`lsu_r_valid` or `lsu_w_ready`), with loaded data extracted and sign/zero-extended. Sits between the MEM/WB pipeline register and the data SRAM/bus bridge.

## Interface
- `ADDR_W`, 32, byte address width.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `lsu_r_ready`  in  1  load request; sampled only when `lsu_idle`=1
- `lsu_w_valid`  in  1  store request; sampled only when `lsu_idle`=1
- `lsu_addr`  in  ADDR_W  byte address
- `lsu_funct3`  in  3  RISC-V size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU (stores use bits[1:0])
- `lsu_w_data`  in  64  store data, right-aligned
- `lsu_idle`  out  1  ready to accept a request
- `lsu_r_valid`  out  1  one-cycle pulse: load complete, `lsu_r_data` valid
- `lsu_r_data`  out  64  extended load data; holds value until next load completes
- `lsu_w_ready`  out  1  one-cycle pulse: store complete
- `lsu_misalign`  out  1  one-cycle pulse alongside completion when the access was misaligned
- `mem_req`  out  1  backend request; held until `mem_gnt`
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  `lsu_addr` with bits[2:0] cleared
- `mem_wdata`  out  64  store data shifted left by 8*addr[2:0]; unused bytes 0
- `mem_wstrb`  out  8  byte enables; 0 for reads
- `mem_gnt`  in  1  backend accepted request
- `mem_rvalid`  in  1  backend response (read data, or write ack)
- `mem_rdata`  in  64  backend read data

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `lsu_idle`=1. On `lsu_w_valid` or `lsu_r_ready`: latch addr, funct3, data, kind. Both asserted: store wins, load dropped. Aligned -> REQ. Misaligned (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0) -> RESP with misalign flag, no backend access.
- REQ: `mem_req`=1 with `mem_we/mem_addr/mem_wdata/mem_wstrb` stable. `mem_gnt`=1 -> WAIT. `mem_rvalid` ignored.
- WAIT: `mem_req`=0. `mem_rvalid`=1 -> capture `mem_rdata` (loads), -> RESP.
- RESP: pulse `lsu_r_valid` (load) or `lsu_w_ready` (store), plus `lsu_misalign` if flagged. `lsu_idle`=1; a new request here is accepted exactly as in IDLE (back-to-back). Otherwise -> IDLE.
- Load extraction: byte lane = addr[2:0]; B/H/W sign-extend from bit 7/15/31; BU/HU/WU zero-extend; D passes 64 bits. Misaligned load: `lsu_r_data`=0.
- Store strobes: B 1 bit, H 2 bits, W 4 bits, D 8'hFF, shifted left by addr[2:0].
- Requests while `lsu_idle`=0 are ignored (no queueing).

## Timing
- Reset: state IDLE; `lsu_idle`=1; `lsu_r_valid`, `lsu_w_ready`, `lsu_misalign`, `mem_req`, `mem_we`=0; `lsu_r_data`, `mem_addr`, `mem_wdata`, `mem_wstrb`=0.
- All outputs registered except `lsu_idle` (decoded from state).
- Request at cycle T -> `mem_req` at T+1. Grant at T+1 and `mem_rvalid` at T+2 -> completion pulse at T+3 (minimum 3-cycle latency). Each gnt/rvalid wait cycle adds one.
- Misaligned request at T -> completion + `lsu_misalign` at T+1.
- Back-to-back: request accepted in RESP cycle T+3 -> next `mem_req` at T+4.
- Reset mid-operation: next cycle IDLE, `mem_req`=0, pending completion discarded; stray `mem_rvalid` in IDLE ignored.

## Test plan
- LW, addr 0x8000_0000, `mem_rdata`=0x1122_3344_8899_AABB, gnt at T+1, rvalid at T+2 -> `lsu_r_valid` at T+3, `lsu_r_data`=0xFFFF_FFFF_8899_AABB.
- LBU addr 0x8000_0006, same rdata -> `lsu_r_data`=0x22; LHU addr 0x...4 -> 0x3344; LD -> full word.
- SH addr 0x8000_0002, data 0xBEEF -> `mem_we`=1, `mem_addr`=0x8000_0000, `mem_wstrb`=8'b0000_1100, `mem_wdata`=0x0000_0000_BEEF_0000; `lsu_w_ready` one cycle after rvalid.
- `mem_gnt` held low 3 cycles -> `mem_req` and fields stable throughout; completion delayed 3 cycles.
- LW addr 0x8000_0002 -> no `mem_req`; next cycle `lsu_r_valid`=1, `lsu_misalign`=1, `lsu_r_data`=0.
- Load then store issued in the RESP cycle -> second `mem_req` next cycle; `rst` asserted in WAIT -> IDLE, `mem_req`=0, later `mem_rvalid` produces no completion pulse.

Source files
------------

// File: rtl/lsu_mem_resp.sv
// lsu_mem_resp: load/store responder between the MEM/WB pipeline register and
// the data SRAM / bus bridge.
//
// Takes one load or store at a time, issues it as an aligned 64-bit access on
// a req/gnt/rvalid port, and returns a one-cycle completion pulse. Loaded data
// is extracted from its byte lane and sign/zero-extended. Misaligned accesses
// complete the next cycle with lsu_misalign set and never reach the backend.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   lsu_r_ready         load request (sampled while lsu_idle)
//   lsu_w_valid         store request (sampled while lsu_idle, wins over load)
//   lsu_addr/funct3     byte address, RISC-V size/sign code
//   lsu_w_data          right-aligned store data
//   lsu_idle            can accept a request this cycle
//   lsu_r_valid/r_data  load completion pulse / extended load data (held)
//   lsu_w_ready         store completion pulse
//   lsu_misalign        pulse alongside completion of a misaligned access
//   mem_req/we/addr/wdata/wstrb  backend request, held until mem_gnt
//   mem_gnt/rvalid/rdata         backend grant, response, read data
module lsu_mem_resp #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_r_ready,
  input  logic              lsu_w_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [2:0]        lsu_funct3,
  input  logic [63:0]       lsu_w_data,
  output logic              lsu_idle,
  output logic              lsu_r_valid,
  output logic [63:0]       lsu_r_data,
  output logic              lsu_w_ready,
  output logic              lsu_misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic        r_is_store;
  logic [2:0]  r_f3;
  logic [2:0]  r_off;

  logic        w_accept;
  logic        w_misalign;
  logic [63:0] w_size_mask;
  logic [7:0]  w_strb_base;
  logic [63:0] w_st_data;
  logic [7:0]  w_st_strb;
  logic [63:0] w_rd_shift;
  logic [63:0] w_ld_data;

  // RESP doubles as an accept cycle so back-to-back requests lose no cycle.
  assign lsu_idle = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_accept = lsu_idle && (lsu_w_valid || lsu_r_ready);

  // Access size decode from funct3[1:0]; bit 2 only selects zero-extension.
  always_comb begin
    w_size_mask = 64'hFF;
    w_strb_base = 8'h01;
    w_misalign  = 1'b0;
    case (lsu_funct3[1:0])
      2'b00: begin
        w_size_mask = 64'h0000_0000_0000_00FF;
        w_strb_base = 8'h01;
        w_misalign  = 1'b0;
      end
      2'b01: begin
        w_size_mask = 64'h0000_0000_0000_FFFF;
        w_strb_base = 8'h03;
        w_misalign  = lsu_addr[0];
      end
      2'b10: begin
        w_size_mask = 64'h0000_0000_FFFF_FFFF;
        w_strb_base = 8'h0F;
        w_misalign  = |lsu_addr[1:0];
      end
      default: begin
        w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        w_strb_base = 8'hFF;
        w_misalign  = |lsu_addr[2:0];
      end
    endcase
  end

  assign w_st_data = (lsu_w_data & w_size_mask) << {lsu_addr[2:0], 3'b000};
  assign w_st_strb = w_strb_base << lsu_addr[2:0];

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  assign w_rd_shift = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = w_rd_shift;
    case (r_f3)
      3'b000:  w_ld_data = {{56{w_rd_shift[7]}},  w_rd_shift[7:0]};
      3'b001:  w_ld_data = {{48{w_rd_shift[15]}}, w_rd_shift[15:0]};
      3'b010:  w_ld_data = {{32{w_rd_shift[31]}}, w_rd_shift[31:0]};
      3'b100:  w_ld_data = {56'd0, w_rd_shift[7:0]};
      3'b101:  w_ld_data = {48'd0, w_rd_shift[15:0]};
      3'b110:  w_ld_data = {32'd0, w_rd_shift[31:0]};
      default: w_ld_data = w_rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_f3         <= 3'd0;
      r_off        <= 3'd0;
      lsu_r_valid  <= 1'b0;
      lsu_w_ready  <= 1'b0;
      lsu_misalign <= 1'b0;
      lsu_r_data   <= 64'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 64'd0;
      mem_wstrb    <= 8'd0;
    end else begin
      // Completion outputs are single-cycle pulses.
      lsu_r_valid  <= 1'b0;
      lsu_w_ready  <= 1'b0;
      lsu_misalign <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_is_store <= lsu_w_valid;
            r_f3       <= lsu_funct3;
            r_off      <= lsu_addr[2:0];
            if (w_misalign) begin
              // Short-circuit: complete next cycle, backend untouched.
              r_state      <= S_RESP;
              lsu_misalign <= 1'b1;
              if (lsu_w_valid) begin
                lsu_w_ready <= 1'b1;
              end else begin
                lsu_r_valid <= 1'b1;
                lsu_r_data  <= 64'd0;
              end
            end else begin
              r_state   <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= lsu_w_valid;
              mem_addr  <= {lsu_addr[ADDR_W-1:3], 3'b000};
              mem_wdata <= lsu_w_valid ? w_st_data : 64'd0;
              mem_wstrb <= lsu_w_valid ? w_st_strb : 8'd0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_state <= S_RESP;
            if (r_is_store) begin
              lsu_w_ready <= 1'b1;
            end else begin
              lsu_r_valid <= 1'b1;
              lsu_r_data  <= w_ld_data;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_resp.sv
module tb_lsu_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_r_ready, lsu_w_valid;
  logic [31:0] lsu_addr;
  logic [2:0]  lsu_funct3;
  logic [63:0] lsu_w_data;
  logic        lsu_idle, lsu_r_valid, lsu_w_ready, lsu_misalign;
  logic [63:0] lsu_r_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  bit drive_both = 0;
  bit busy_poke  = 0;

  typedef struct packed {
    logic        st;
    logic        mis;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  localparam logic [63:0] RD = 64'h1122_3344_8899_AABB;

  lsu_mem_resp #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_r_ready(lsu_r_ready), .lsu_w_valid(lsu_w_valid),
    .lsu_addr(lsu_addr), .lsu_funct3(lsu_funct3), .lsu_w_data(lsu_w_data),
    .lsu_idle(lsu_idle), .lsu_r_valid(lsu_r_valid), .lsu_r_data(lsu_r_data),
    .lsu_w_ready(lsu_w_ready), .lsu_misalign(lsu_misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load result, built byte by byte.
  function automatic logic [63:0] ld_model(logic [2:0] f3, logic [2:0] off, logic [63:0] rd);
    int n = 1 << f3[1:0];
    logic [63:0] v = 64'd0;
    for (int i = 0; i < 8; i++) begin
      int idx = int'(off) + i;
      if (i < n && idx < 8) v[8*i +: 8] = rd[8*idx +: 8];
    end
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = 0; i < 8; i++) if (i >= n) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // One access: request, backend handshake with optional stalls, completion.
  task automatic run_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [63:0] rd,
                            input int gdly, input int rdly, input bit b2b,
                            input bit exp_mis, input logic [63:0] exp_wdata,
                            input logic [7:0] exp_strb, input logic [63:0] exp_rdata);
    exp_t e;
    e.st = st; e.mis = exp_mis; e.data = exp_rdata;
    sb.push_back(e);
    lsu_w_valid = st;
    lsu_r_ready = !st || drive_both;
    lsu_addr = addr; lsu_funct3 = f3; lsu_w_data = wd;
    tick();
    lsu_w_valid = 0; lsu_r_ready = 0;
    if (!exp_mis) begin
      checks++;
      if (mem_req !== 1'b1 || lsu_idle !== 1'b0) begin
        errors++;
        $display("FAIL req_issue: mem_req=%b idle=%b, want 1/0", mem_req, lsu_idle);
      end
      checks++;
      if (mem_we !== st || mem_addr !== (addr & 32'hFFFF_FFF8)) begin
        errors++;
        $display("FAIL req_fields: we=%b addr=%h, want %b %h", mem_we, mem_addr, st, addr & 32'hFFFF_FFF8);
      end
      checks++;
      if (mem_wdata !== exp_wdata || mem_wstrb !== exp_strb) begin
        errors++;
        $display("FAIL req_wdata: wdata=%h strb=%b, want %h %b", mem_wdata, mem_wstrb, exp_wdata, exp_strb);
      end
      mem_gnt = 0;
      for (int i = 0; i < gdly; i++) begin
        if (busy_poke) begin
          lsu_r_ready = 1; lsu_w_valid = 1; lsu_addr = 32'h0000_0010; lsu_funct3 = 3'b011;
        end
        mem_rvalid = 1;  // must be ignored while requesting
        tick();
        mem_rvalid = 0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== (addr & 32'hFFFF_FFF8) || mem_wdata !== exp_wdata ||
            mem_wstrb !== exp_strb || lsu_r_valid !== 1'b0 || lsu_w_ready !== 1'b0) begin
          errors++;
          $display("FAIL req_stall: req=%b addr=%h wdata=%h strb=%b rv=%b wr=%b, want stable 1 %h %h %b 0 0",
                   mem_req, mem_addr, mem_wdata, mem_wstrb, lsu_r_valid, lsu_w_ready,
                   addr & 32'hFFFF_FFF8, exp_wdata, exp_strb);
        end
      end
      lsu_r_ready = 0; lsu_w_valid = 0;
      mem_gnt = 1;
      tick();
      mem_gnt = 0;
      checks++;
      if (mem_req !== 1'b0 || lsu_idle !== 1'b0) begin
        errors++;
        $display("FAIL wait_state: mem_req=%b idle=%b, want 0/0", mem_req, lsu_idle);
      end
      for (int i = 0; i < rdly; i++) tick();
      mem_rvalid = 1; mem_rdata = rd;
      tick();
      mem_rvalid = 0; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    end else begin
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL mis_noreq: mem_req=%b, want 0", mem_req);
      end
    end
    // Completion must be present exactly now; pop and compare.
    checks++;
    if (!(lsu_r_valid || lsu_w_ready)) begin
      errors++;
      $display("FAIL completion_latency: r_valid=%b w_ready=%b, want a pulse", lsu_r_valid, lsu_w_ready);
      void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL completion_unexpected: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (lsu_w_ready !== e.st || lsu_r_valid !== !e.st || lsu_misalign !== e.mis ||
          lsu_idle !== 1'b1 || (!e.st && lsu_r_data !== e.data)) begin
        errors++;
        $display("FAIL completion: wr=%b rv=%b mis=%b idle=%b data=%h, want wr=%b mis=%b data=%h",
                 lsu_w_ready, lsu_r_valid, lsu_misalign, lsu_idle, lsu_r_data, e.st, e.mis, e.data);
      end
    end
    if (!b2b) begin
      tick();
      checks++;
      if (lsu_r_valid !== 1'b0 || lsu_w_ready !== 1'b0 || lsu_misalign !== 1'b0 ||
          lsu_idle !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL pulse_drop: rv=%b wr=%b mis=%b idle=%b req=%b, want 0 0 0 1 0",
                 lsu_r_valid, lsu_w_ready, lsu_misalign, lsu_idle, mem_req);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++;
    if (lsu_idle !== 1'b1 || lsu_r_valid !== 1'b0 || lsu_w_ready !== 1'b0 || lsu_misalign !== 1'b0 ||
        mem_req !== 1'b0 || mem_we !== 1'b0 || lsu_r_data !== 64'd0 || mem_addr !== 32'd0 ||
        mem_wdata !== 64'd0 || mem_wstrb !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: idle=%b rv=%b wr=%b mis=%b req=%b we=%b rd=%h ma=%h wd=%h ws=%h, want 1 and zeros",
               lsu_idle, lsu_r_valid, lsu_w_ready, lsu_misalign, mem_req, mem_we,
               lsu_r_data, mem_addr, mem_wdata, mem_wstrb);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_loads();
    run_access(0, 3'b010, 32'h8000_0000, 0, RD, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_8899_AABB); // LW
    run_access(0, 3'b100, 32'h8000_0006, 0, RD, 0, 0, 0, 0, 0, 0, 64'h22);                  // LBU
    run_access(0, 3'b101, 32'h8000_0004, 0, RD, 0, 0, 0, 0, 0, 0, 64'h3344);                // LHU
    run_access(0, 3'b011, 32'h8000_0000, 0, RD, 0, 0, 0, 0, 0, 0, RD);                      // LD
    run_access(0, 3'b000, 32'h8000_0001, 0, RD, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFAA); // LB
    run_access(0, 3'b001, 32'h8000_0002, 0, RD, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_8899); // LH
    run_access(0, 3'b110, 32'h8000_0000, 0, RD, 0, 0, 0, 0, 0, 0, 64'h8899_AABB);           // LWU
    run_access(0, 3'b010, 32'h8000_0004, 0, RD, 0, 0, 0, 0, 0, 0, 64'h1122_3344);           // LW +
  endtask

  task automatic test_stores();
    run_access(1, 3'b001, 32'h8000_0002, 64'hBEEF, 0, 0, 0, 0, 0,
               64'h0000_0000_BEEF_0000, 8'b0000_1100, 0);                                    // SH
    run_access(1, 3'b000, 32'h8000_0007, 64'h1234_56AB, 0, 0, 1, 0, 0,
               64'hAB00_0000_0000_0000, 8'h80, 0);                                           // SB
    run_access(1, 3'b010, 32'h8000_0004, 64'hFFFF_FFFF_DEAD_BEEF, 0, 0, 0, 0, 0,
               64'hDEAD_BEEF_0000_0000, 8'hF0, 0);                                           // SW
    run_access(1, 3'b011, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0,
               64'h0123_4567_89AB_CDEF, 8'hFF, 0);                                           // SD
  endtask

  task automatic test_gnt_stall();
    // Grant held off 3 cycles with requests poked while busy: only one access.
    busy_poke = 1;
    run_access(0, 3'b010, 32'h8000_0000, 0, RD, 3, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_8899_AABB);
    busy_poke = 0;
    run_access(1, 3'b000, 32'h8000_0003, 64'h5A, 0, 2, 2, 0, 0, 64'h0000_0000_5A00_0000, 8'h08, 0);
  endtask

  task automatic test_misalign();
    run_access(0, 3'b010, 32'h8000_0002, 0, 0, 0, 0, 0, 1, 0, 0, 64'd0);   // LW
    run_access(0, 3'b001, 32'h8000_0001, 0, 0, 0, 0, 0, 1, 0, 0, 64'd0);   // LH
    run_access(1, 3'b011, 32'h8000_0004, 64'h1, 0, 0, 0, 0, 1, 0, 0, 0);   // SD
  endtask

  task automatic test_store_wins();
    drive_both = 1;
    run_access(1, 3'b010, 32'h8000_0000, 64'h0000_0000_CAFE_F00D, 0, 0, 0, 0, 0,
               64'h0000_0000_CAFE_F00D, 8'h0F, 0);
    drive_both = 0;
  endtask

  task automatic test_back_to_back();
    run_access(0, 3'b011, 32'h8000_0010, 0, RD, 0, 0, 1, 0, 0, 0, RD);
    run_access(1, 3'b001, 32'h8000_0016, 64'h7777, 0, 0, 0, 1, 0, 64'h7777_0000_0000_0000, 8'hC0, 0);
    run_access(0, 3'b010, 32'h8000_0001, 0, 0, 0, 0, 1, 1, 0, 0, 64'd0);
    run_access(0, 3'b000, 32'h8000_0005, 0, RD, 0, 0, 0, 0, 0, 0, 64'h33);
  endtask

  task automatic test_reset_mid();
    lsu_r_ready = 1; lsu_addr = 32'h8000_0000; lsu_funct3 = 3'b010;
    tick();
    lsu_r_ready = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (mem_req !== 1'b0 || lsu_idle !== 1'b1 || lsu_r_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b idle=%b rv=%b, want 0 1 0", mem_req, lsu_idle, lsu_r_valid);
    end
    mem_rvalid = 1; mem_rdata = RD;
    tick();
    mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lsu_r_valid !== 1'b0 || lsu_w_ready !== 1'b0 || mem_req !== 1'b0 || lsu_r_data !== 64'd0) begin
        errors++;
        $display("FAIL stray_rvalid: rv=%b wr=%b req=%b rd=%h, want 0 0 0 0",
                 lsu_r_valid, lsu_w_ready, mem_req, lsu_r_data);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      bit st = 1'($urandom_range(0, 1));
      logic [2:0] f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      logic [31:0] addr = $urandom;
      logic [63:0] wd = {$urandom, $urandom};
      logic [63:0] rd = {$urandom, $urandom};
      int n = 1 << f3[1:0];
      bit mis = (int'(addr[2:0]) % n) != 0;
      logic [63:0] ewd = 64'd0;
      logic [7:0]  est = 8'd0;
      logic [63:0] erd = 64'd0;
      if (st) begin
        for (int i = 0; i < n; i++) begin
          if (int'(addr[2:0]) + i < 8) begin
            est[int'(addr[2:0]) + i] = 1'b1;
            ewd[8*(int'(addr[2:0]) + i) +: 8] = wd[8*i +: 8];
          end
        end
      end else if (!mis) begin
        erd = ld_model(f3, addr[2:0], rd);
      end
      run_access(st, f3, addr, wd, rd, $urandom_range(0, 2), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), mis, ewd, est, erd);
    end
    tick();
  endtask

  initial begin
    rst = 1; lsu_r_ready = 0; lsu_w_valid = 0; lsu_addr = 0; lsu_funct3 = 0; lsu_w_data = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    test_reset();
    test_loads();
    test_stores();
    test_gnt_stall();
    test_misalign();
    test_store_wins();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
